project1_sequencer: RTL and testbench

Operand-entry controller that sequences the Project1 arithmetic/display datapath on the DE10-Lite board. It debounces the KEY pushbuttons and steps through three phases: enter operand A, enter operand B, show result. Each operand is captured from SW[3:0] and the mode from SW[9]. It drives registered operands, a compute strobe and status to the Project1 datapath, which keeps HEX/LEDR decoding.

---
 rtl/project1_pkg.sv | 18 +
 rtl/key_debounce.sv | 64 ++++++
 rtl/project1_sequencer.sv | 131 +++++++++++++
 tb/tb_project1_sequencer.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/project1_pkg.sv
// Shared definitions for the Project1 operand-entry sequencer:
// STATE encodings and default timing constants for a 50 MHz clock.
package project1_pkg;

  localparam logic [1:0] ENTER_A = 2'b00;
  localparam logic [1:0] ENTER_B = 2'b01;
  localparam logic [1:0] SHOW    = 2'b10;

  localparam int DEFAULT_DEBOUNCE_CYCLES = 500000;
  localparam int DEFAULT_BLINK_CYCLES    = 12500000;

  typedef enum logic [1:0] {
    S_ENTER_A = ENTER_A,
    S_ENTER_B = ENTER_B,
    S_SHOW    = SHOW
  } state_e;

endpackage

// File: rtl/key_debounce.sv
// Synchronizes and debounces one active-low pushbutton and emits a
// single-cycle pulse on each accepted press (debounced 1->0 edge).
module key_debounce
  import project1_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic reset,
  input  logic key,
  output logic press
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ZERO = CW'(0);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  logic          sync1_r;
  logic          sync2_r;
  logic          level_r;
  logic          arm_r;
  logic          press_r;
  logic [CW-1:0] cnt_r;

  // arm_r stays low until a genuine released level has been seen after reset,
  // so a key held through reset debounces silently and never pulses.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_r <= 1'b1;
      sync2_r <= 1'b1;
      level_r <= 1'b1;
      arm_r   <= 1'b0;
      press_r <= 1'b0;
      cnt_r   <= CNT_ZERO;
    end else begin
      sync1_r <= key;
      sync2_r <= sync1_r;
      press_r <= 1'b0;
      if (sync2_r != level_r) begin
        if (cnt_r == CNT_LAST) begin
          level_r <= sync2_r;
          cnt_r   <= CNT_ZERO;
          press_r <= arm_r & ~sync2_r;
          arm_r   <= arm_r | sync2_r;
        end else begin
          cnt_r <= cnt_r + CNT_ONE;
        end
      end else if (!arm_r && level_r) begin
        if (cnt_r == CNT_LAST) begin
          arm_r <= 1'b1;
          cnt_r <= CNT_ZERO;
        end else begin
          cnt_r <= cnt_r + CNT_ONE;
        end
      end else begin
        cnt_r <= CNT_ZERO;
      end
    end
  end

  assign press = press_r;

endmodule

// File: rtl/project1_sequencer.sv
// Three-phase operand-entry controller (enter A, enter B, show result)
// driving registered operands, a compute strobe and status to the datapath.
module project1_sequencer
  import project1_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int BLINK_CYCLES    = DEFAULT_BLINK_CYCLES
) (
  input  logic       MAX10_CLK1_50,
  input  logic       RESET,
  input  logic [9:0] SW,
  input  logic [1:0] KEY,
  output logic [3:0] OP_A,
  output logic [3:0] OP_B,
  output logic       MODE,
  output logic       START,
  output logic       RESULT_VALID,
  output logic [1:0] STATE,
  output logic       BLINK
);

  localparam int BW = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_CYCLES - 1);
  localparam logic [BW-1:0] BLINK_ZERO = BW'(0);
  localparam logic [BW-1:0] BLINK_ONE  = BW'(1);

  state_e          state_r, state_nxt_s;
  logic [3:0]      op_a_r, op_a_nxt_s;
  logic [3:0]      op_b_r, op_b_nxt_s;
  logic            mode_r, mode_nxt_s;
  logic            start_r, start_nxt_s;
  logic            valid_r, valid_nxt_s;
  logic            blink_r, blink_nxt_s;
  logic [BW-1:0]   blink_cnt_r, blink_cnt_nxt_s;
  logic            press0_s;
  logic            press1_s;
  logic            unused_sw_s;

  assign unused_sw_s = ^SW[8:4];

  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key0 (
    .clk   (MAX10_CLK1_50),
    .reset (RESET),
    .key   (KEY[0]),
    .press (press0_s)
  );

  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key1 (
    .clk   (MAX10_CLK1_50),
    .reset (RESET),
    .key   (KEY[1]),
    .press (press1_s)
  );

  // Next-state, capture and blink-timer logic; clear (press1) outranks advance.
  always_comb begin
    state_nxt_s = state_r;
    op_a_nxt_s  = op_a_r;
    op_b_nxt_s  = op_b_r;
    mode_nxt_s  = mode_r;
    start_nxt_s = 1'b0;
    if (press1_s) begin
      state_nxt_s = S_ENTER_A;
      op_a_nxt_s  = 4'h0;
      op_b_nxt_s  = 4'h0;
      mode_nxt_s  = 1'b0;
    end else if (press0_s) begin
      case (state_r)
        S_ENTER_A: begin
          op_a_nxt_s  = SW[3:0];
          state_nxt_s = S_ENTER_B;
        end
        S_ENTER_B: begin
          op_b_nxt_s  = SW[3:0];
          mode_nxt_s  = SW[9];
          state_nxt_s = S_SHOW;
          start_nxt_s = 1'b1;
        end
        S_SHOW:  state_nxt_s = S_ENTER_A;
        default: state_nxt_s = S_ENTER_A;
      endcase
    end else begin
      state_nxt_s = state_r;
    end

    valid_nxt_s     = (state_nxt_s == S_SHOW);
    blink_nxt_s     = blink_r;
    blink_cnt_nxt_s = blink_cnt_r;
    if ((state_nxt_s != state_r) || (state_r == S_SHOW)) begin
      blink_nxt_s     = 1'b0;
      blink_cnt_nxt_s = BLINK_ZERO;
    end else if (blink_cnt_r == BLINK_LAST) begin
      blink_nxt_s     = ~blink_r;
      blink_cnt_nxt_s = BLINK_ZERO;
    end else begin
      blink_cnt_nxt_s = blink_cnt_r + BLINK_ONE;
    end
  end

  // State and output registers.
  always_ff @(posedge MAX10_CLK1_50) begin
    if (RESET) begin
      state_r     <= S_ENTER_A;
      op_a_r      <= 4'h0;
      op_b_r      <= 4'h0;
      mode_r      <= 1'b0;
      start_r     <= 1'b0;
      valid_r     <= 1'b0;
      blink_r     <= 1'b0;
      blink_cnt_r <= BLINK_ZERO;
    end else begin
      state_r     <= state_nxt_s;
      op_a_r      <= op_a_nxt_s;
      op_b_r      <= op_b_nxt_s;
      mode_r      <= mode_nxt_s;
      start_r     <= start_nxt_s;
      valid_r     <= valid_nxt_s;
      blink_r     <= blink_nxt_s;
      blink_cnt_r <= blink_cnt_nxt_s;
    end
  end

  assign OP_A         = op_a_r;
  assign OP_B         = op_b_r;
  assign MODE         = mode_r;
  assign START        = start_r;
  assign RESULT_VALID = valid_r;
  assign STATE        = state_r;
  assign BLINK        = blink_r;

endmodule

// File: tb/tb_project1_sequencer.sv
// Directed self-checking bench for project1_sequencer with short debounce
// and blink periods; outputs are sampled on the falling clock edge.
module tb_project1_sequencer;

  logic       clk;
  logic       reset;
  logic [9:0] sw;
  logic [1:0] key;
  logic [3:0] op_a;
  logic [3:0] op_b;
  logic       mode;
  logic       start;
  logic       result_valid;
  logic [1:0] state;
  logic       blink;

  int checks;
  int errors;
  int start_cnt;
  int start_good;
  logic [1:0] prev_state;

  project1_sequencer #(.DEBOUNCE_CYCLES(4), .BLINK_CYCLES(8)) dut (
    .MAX10_CLK1_50 (clk),
    .RESET         (reset),
    .SW            (sw),
    .KEY           (key),
    .OP_A          (op_a),
    .OP_B          (op_b),
    .MODE          (mode),
    .START         (start),
    .RESULT_VALID  (result_valid),
    .STATE         (state),
    .BLINK         (blink)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance n cycles, tallying START pulses and whether each lands on the first SHOW cycle.
  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (start === 1'b1) begin
        start_cnt++;
        if (state === 2'b10 && prev_state !== 2'b10) start_good++;
      end
      prev_state = state;
    end
  endtask

  task automatic press(input logic [1:0] which, input int hold);
    key = 2'b11 & ~which;
    cycles(hold);
    key = 2'b11;
    cycles(12);
  endtask

  task automatic test_reset;
    sw = 10'h000;
    key = 2'b11;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    prev_state = state;
    checks++; if (op_a !== 4'h0) begin errors++; $display("FAIL reset_op_a: got %h expected 0", op_a); end
    checks++; if (op_b !== 4'h0) begin errors++; $display("FAIL reset_op_b: got %h expected 0", op_b); end
    checks++; if ({mode, start, result_valid, blink} !== 4'b0000) begin errors++; $display("FAIL reset_flags: got %b expected 0000", {mode, start, result_valid, blink}); end
    checks++; if (state !== 2'b00) begin errors++; $display("FAIL reset_state: got %b expected 00", state); end
    cycles(7);
    checks++; if (blink !== 1'b0) begin errors++; $display("FAIL blink_pre: got %b expected 0", blink); end
    cycles(1);
    checks++; if (blink !== 1'b1) begin errors++; $display("FAIL blink_on: got %b expected 1", blink); end
    cycles(8);
    checks++; if (blink !== 1'b0) begin errors++; $display("FAIL blink_off: got %b expected 0", blink); end
  endtask

  task automatic test_capture;
    start_cnt = 0; start_good = 0;
    sw = 10'h00A;
    press(2'b01, 10);
    checks++; if (op_a !== 4'hA) begin errors++; $display("FAIL cap_op_a: got %h expected a", op_a); end
    checks++; if (state !== 2'b01) begin errors++; $display("FAIL cap_state_b: got %b expected 01", state); end
    checks++; if (start_cnt !== 0) begin errors++; $display("FAIL cap_no_start: got %0d expected 0", start_cnt); end
    sw = 10'h205;
    press(2'b01, 10);
    checks++; if (op_b !== 4'h5) begin errors++; $display("FAIL cap_op_b: got %h expected 5", op_b); end
    checks++; if (mode !== 1'b1) begin errors++; $display("FAIL cap_mode: got %b expected 1", mode); end
    checks++; if (state !== 2'b10) begin errors++; $display("FAIL cap_state_show: got %b expected 10", state); end
    checks++; if (result_valid !== 1'b1) begin errors++; $display("FAIL cap_valid: got %b expected 1", result_valid); end
    checks++; if (blink !== 1'b0) begin errors++; $display("FAIL cap_blink: got %b expected 0", blink); end
    checks++; if (op_a !== 4'hA) begin errors++; $display("FAIL cap_op_a_kept: got %h expected a", op_a); end
    checks++; if (start_cnt !== 1) begin errors++; $display("FAIL start_count: got %0d expected 1", start_cnt); end
    checks++; if (start_good !== 1) begin errors++; $display("FAIL start_align: got %0d expected 1", start_good); end
  endtask

  task automatic test_show_advance;
    sw = 10'h000;
    press(2'b01, 10);
    checks++; if (state !== 2'b00) begin errors++; $display("FAIL show_adv_state: got %b expected 00", state); end
    checks++; if ({op_a, op_b} !== 8'hA5) begin errors++; $display("FAIL show_adv_ops: got %h expected a5", {op_a, op_b}); end
    checks++; if (mode !== 1'b1) begin errors++; $display("FAIL show_adv_mode: got %b expected 1", mode); end
    checks++; if (result_valid !== 1'b0) begin errors++; $display("FAIL show_adv_valid: got %b expected 0", result_valid); end
  endtask

  task automatic test_simultaneous;
    sw = 10'h00A;
    press(2'b01, 10);
    sw = 10'h205;
    press(2'b01, 10);
    checks++; if (state !== 2'b10) begin errors++; $display("FAIL simul_setup: got %b expected 10", state); end
    start_cnt = 0;
    press(2'b11, 10);
    checks++; if (state !== 2'b00) begin errors++; $display("FAIL simul_state: got %b expected 00", state); end
    checks++; if ({op_a, op_b, 3'b000, mode} !== 12'h000) begin errors++; $display("FAIL simul_clear: got %h expected 000", {op_a, op_b, 3'b000, mode}); end
    checks++; if (start_cnt !== 0) begin errors++; $display("FAIL simul_no_start: got %0d expected 0", start_cnt); end
  endtask

  task automatic test_bounce;
    sw = 10'h003;
    for (int i = 0; i < 6; i++) begin
      key[0] = i[0];
      cycles(2);
    end
    press(2'b01, 10);
    checks++; if (state !== 2'b01) begin errors++; $display("FAIL bounce_state: got %b expected 01", state); end
    checks++; if (op_a !== 4'h3) begin errors++; $display("FAIL bounce_op_a: got %h expected 3", op_a); end
    sw = 10'h007;
    press(2'b01, 3);
    checks++; if (state !== 2'b01) begin errors++; $display("FAIL glitch_state: got %b expected 01", state); end
    checks++; if (op_b !== 4'h0) begin errors++; $display("FAIL glitch_op_b: got %h expected 0", op_b); end
  endtask

  task automatic test_held_reset;
    start_cnt = 0;
    key = 2'b10;
    cycles(1);
    reset = 1'b1;
    cycles(1);
    reset = 1'b0;
    sw = 10'h009;
    cycles(20);
    checks++; if (state !== 2'b00) begin errors++; $display("FAIL held_state: got %b expected 00", state); end
    checks++; if (op_a !== 4'h0) begin errors++; $display("FAIL held_op_a: got %h expected 0", op_a); end
    key = 2'b11;
    cycles(12);
    press(2'b01, 10);
    checks++; if (op_a !== 4'h9) begin errors++; $display("FAIL repress_op_a: got %h expected 9", op_a); end
    checks++; if (state !== 2'b01) begin errors++; $display("FAIL repress_state: got %b expected 01", state); end
    checks++; if (start_cnt !== 0) begin errors++; $display("FAIL held_no_start: got %0d expected 0", start_cnt); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    start_cnt = 0;
    start_good = 0;
    prev_state = 2'b00;
    reset = 1'b1;
    sw = 10'h000;
    key = 2'b11;
    test_reset();
    test_capture();
    test_show_advance();
    test_simultaneous();
    test_bounce();
    test_held_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
